// File: rtl/watchdog_supervisor.sv
// Supervises a hardware watchdog: kicks it only when every enabled liveness
// source has checked in during the current epoch, and sequences fault recovery.
module watchdog_supervisor #(
  parameter int NUM_SRC      = 4,
  parameter int EPOCH_CYCLES = 1024,
  parameter int MUTE_HOLD    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_alive,
  input  logic               wd_warning,
  input  logic               wd_triggered,
  input  logic               clear_fault,
  output logic               wd_enable,
  output logic               wd_heartbeat,
  output logic               wd_force_reset,
  output logic               rf_mute,
  output logic               fault_latched,
  output logic [NUM_SRC-1:0] missed_src,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int CW = $clog2(EPOCH_CYCLES);
  localparam int HW = $clog2(MUTE_HOLD + 1);
  localparam logic [CW-1:0] EPOCH_LAST = CW'(EPOCH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(MUTE_HOLD - 1);

  state_t               state_q, state_n;
  logic [NUM_SRC-1:0]   seen_q, seen_n;
  logic [NUM_SRC-1:0]   missed_q, missed_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [HW-1:0]        hold_q, hold_n;
  logic                 enable_q, hb_q, fr_q, mute_q, fault_q;
  logic                 hb_n, fr_n;
  logic [NUM_SRC-1:0]   live;
  logic                 covered;

  // The pre-expiry flag is informational only; nothing in the sequencing uses it.
  logic unused_warning;
  assign unused_warning = wd_warning;

  assign live    = src_alive & src_en;
  assign covered = ((seen_q | live) & src_en) == src_en;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state_q;
    seen_n   = seen_q;
    cnt_n    = cnt_q;
    hold_n   = hold_q;
    missed_n = missed_q;
    hb_n     = 1'b0;
    fr_n     = 1'b0;

    case (state_q)
      IDLE: begin
        seen_n = '0;
        cnt_n  = '0;
        if (src_en != '0) state_n = ARMED;
      end

      ARMED: begin
        if (wd_triggered) begin
          // Expiry outranks a same-cycle coverage: a late kick must not mask it.
          state_n = FAULT;
          seen_n  = '0;
          cnt_n   = '0;
        end else if (src_en == '0) begin
          state_n = IDLE;
          seen_n  = '0;
          cnt_n   = '0;
        end else if (covered) begin
          hb_n   = 1'b1;
          seen_n = '0;
          cnt_n  = '0;
        end else if (cnt_q == EPOCH_LAST) begin
          missed_n = src_en & ~seen_q;
          seen_n   = '0;
          cnt_n    = '0;
        end else begin
          seen_n = seen_q | live;
          cnt_n  = cnt_q + CW'(1);
        end
      end

      FAULT: begin
        if (clear_fault) begin
          state_n = RECOVER;
          fr_n    = 1'b1;
          hold_n  = '0;
        end
      end

      RECOVER: begin
        if (hold_q == HOLD_LAST) begin
          state_n = (src_en != '0) ? ARMED : IDLE;
          seen_n  = '0;
          cnt_n   = '0;
          hold_n  = '0;
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Level outputs are decoded from the next state so they change with it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      seen_q   <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      missed_q <= '0;
      enable_q <= 1'b0;
      hb_q     <= 1'b0;
      fr_q     <= 1'b0;
      mute_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      seen_q   <= seen_n;
      cnt_q    <= cnt_n;
      hold_q   <= hold_n;
      missed_q <= missed_n;
      enable_q <= (state_n != IDLE);
      hb_q     <= hb_n;
      fr_q     <= fr_n;
      mute_q   <= (state_n == FAULT) || (state_n == RECOVER);
      fault_q  <= (state_n == FAULT) || (state_n == RECOVER);
    end
  end

  assign wd_enable      = enable_q;
  assign wd_heartbeat   = hb_q;
  assign wd_force_reset = fr_q;
  assign rf_mute        = mute_q;
  assign fault_latched  = fault_q;
  assign missed_src     = missed_q;
  assign state          = state_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed stimulus for watchdog_supervisor; expected output snapshots are queued
// by cycle and a negedge monitor pops and compares them.
module tb_watchdog_supervisor;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_FAULT = 2'd2, S_RECOVER = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_en, src_alive;
  logic       wd_warning, wd_triggered, clear_fault;
  logic       wd_enable, wd_heartbeat, wd_force_reset, rf_mute, fault_latched;
  logic [3:0] missed_src;
  logic [1:0] state;

  watchdog_supervisor #(.NUM_SRC(4), .EPOCH_CYCLES(1024), .MUTE_HOLD(16)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .src_alive(src_alive),
    .wd_warning(wd_warning), .wd_triggered(wd_triggered), .clear_fault(clear_fault),
    .wd_enable(wd_enable), .wd_heartbeat(wd_heartbeat), .wd_force_reset(wd_force_reset),
    .rf_mute(rf_mute), .fault_latched(fault_latched), .missed_src(missed_src),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    logic [10:0] want;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_at(input int lat, input string tag, input logic [1:0] st,
                           input logic en, input logic hb, input logic fr,
                           input logic mute, input logic flt, input logic [3:0] missed);
    exp_t e;
    int   i;
    e.at   = cyc + lat;
    e.tag  = tag;
    e.want = {st, en, hb, fr, mute, flt, missed};
    i = sb.size();
    while (i > 0 && sb[i-1].at > e.at) i--;
    sb.insert(i, e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src_en = '0; src_alive = '0;
    wd_triggered = 1'b0; clear_fault = 1'b0; wd_warning = 1'b0;
    tick(2);
    expect_at(0, "reset_state", S_IDLE, 0, 0, 0, 0, 0, 4'b0000);
    tick(1);
    rst = 1'b0;
  endtask

  logic [10:0] got;
  always @(negedge clk) begin
    got = {state, wd_enable, wd_heartbeat, wd_force_reset, rf_mute, fault_latched, missed_src};
    n_cmp++;
    if (wd_heartbeat && wd_force_reset) begin
      n_bad++;
      $display("FAIL hb_fr_exclusive @cyc %0d: both high", cyc);
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.at != cyc || got !== e.want) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got st=%0d en=%b hb=%b fr=%b mute=%b flt=%b missed=%b, want st=%0d en=%b hb=%b fr=%b mute=%b flt=%b missed=%b",
                 e.tag, cyc, e.at, got[10:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
                 e.want[10:9], e.want[8], e.want[7], e.want[6], e.want[5], e.want[4], e.want[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Coverage across two sources, single-cycle heartbeat, seen cleared afterwards.
    do_reset();
    src_en = 4'b0011;
    expect_at(1, "idle_to_armed", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(4);
    src_alive = 4'b0001;
    expect_at(1, "half_coverage", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(1); src_alive = 4'b0000; tick(3);
    src_alive = 4'b0010;
    expect_at(1, "heartbeat", S_ARMED, 1, 1, 0, 0, 0, 4'b0000);
    expect_at(2, "hb_one_cycle", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(1); src_alive = 4'b0000; tick(2);
    src_alive = 4'b0010;
    expect_at(1, "seen_cleared", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(1); src_alive = 4'b0000; tick(1);
    src_alive = 4'b0011;
    expect_at(1, "same_cycle_cov", S_ARMED, 1, 1, 0, 0, 0, 4'b0000);
    tick(1); src_alive = 4'b0000;
    clear_fault = 1'b1;
    expect_at(1, "clear_in_armed", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(1); clear_fault = 1'b0;
    src_en = 4'b0000;
    expect_at(1, "armed_to_idle", S_IDLE, 0, 0, 0, 0, 0, 4'b0000);
    tick(2);

    // Silent source for a full epoch, then a successful epoch keeps missed_src.
    do_reset();
    src_en = 4'b0001;
    expect_at(1, "b_armed", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    expect_at(1024, "b_epoch_last", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    expect_at(1025, "b_missed_load", S_ARMED, 1, 0, 0, 0, 0, 4'b0001);
    tick(1025);
    src_alive = 4'b0001;
    expect_at(1, "b_hb_keeps_missed", S_ARMED, 1, 1, 0, 0, 0, 4'b0001);
    tick(1); src_alive = 4'b0000; tick(2);

    // Alive on a disabled source is ignored.
    do_reset();
    src_en = 4'b0010;
    expect_at(1, "c_armed", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    expect_at(1024, "c_epoch_last", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    expect_at(1025, "c_missed_load", S_ARMED, 1, 0, 0, 0, 0, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick(100);
      src_alive = 4'b0001;
      expect_at(1, "c_foreign_alive", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
      tick(1); src_alive = 4'b0000;
    end
    tick(730);

    // Trigger beats coverage, fault holds, recovery sequence.
    do_reset();
    src_en = 4'b0001;
    expect_at(1, "d_armed", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(3);
    src_alive = 4'b0001; wd_triggered = 1'b1;
    expect_at(1, "trig_beats_cov", S_FAULT, 1, 0, 0, 1, 1, 4'b0000);
    tick(1); src_alive = 4'b0000; wd_triggered = 1'b0; tick(2);
    src_alive = 4'b0001;
    expect_at(1, "fault_no_hb", S_FAULT, 1, 0, 0, 1, 1, 4'b0000);
    tick(1); src_alive = 4'b0000; tick(2);
    clear_fault = 1'b1;
    expect_at(1, "recover_entry", S_RECOVER, 1, 0, 1, 1, 1, 4'b0000);
    expect_at(2, "force_one_cycle", S_RECOVER, 1, 0, 0, 1, 1, 4'b0000);
    expect_at(16, "mute_last_cycle", S_RECOVER, 1, 0, 0, 1, 1, 4'b0000);
    expect_at(17, "recover_exit", S_ARMED, 1, 0, 0, 0, 0, 4'b0000);
    tick(1); clear_fault = 1'b0; tick(3);
    wd_triggered = 1'b1;
    expect_at(1, "trig_in_recover", S_RECOVER, 1, 0, 0, 1, 1, 4'b0000);
    tick(1); wd_triggered = 1'b0;
    tick(16);

    // Reset on the fifth RECOVER cycle.
    do_reset();
    src_en = 4'b0001;
    tick(3);
    wd_triggered = 1'b1;
    tick(1); wd_triggered = 1'b0;
    clear_fault = 1'b1;
    tick(1); clear_fault = 1'b0;
    tick(4);
    rst = 1'b1;
    expect_at(0, "fifth_recover", S_RECOVER, 1, 0, 0, 1, 1, 4'b0000);
    expect_at(1, "rst_mid_recover", S_IDLE, 0, 0, 0, 0, 0, 4'b0000);
    tick(1);
    src_en = 4'b0000; rst = 1'b0;
    tick(2);

    for (int k = 0; k < 100 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/watchdog_supervisor.md
WATCHDOG_SUPERVISOR -- requirements
Module: watchdog_supervisor

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of liveness sources.
REQ-002 Parameter EPOCH_CYCLES, default 1024, SHALL set the liveness window length in clk cycles (min 4).
REQ-003 Parameter MUTE_HOLD, default 16, SHALL set the RF mute hold time after recovery in clk cycles (min 1).
REQ-004 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 src_en  input  NUM_SRC  SHALL select which sources must check in.
REQ-007 src_alive  input  NUM_SRC  SHALL carry per-source single-cycle check-in pulses.
REQ-008 wd_warning  input  1  SHALL be the watchdog pre-expiry flag; it is status only.
REQ-009 wd_triggered  input  1  SHALL be the watchdog expiry flag.
REQ-010 clear_fault  input  1  SHALL be the host fault-acknowledge pulse.
REQ-011 wd_enable  output  1  SHALL drive the watchdog enable.
REQ-012 wd_heartbeat  output  1  SHALL drive the watchdog kick as a single-cycle pulse.
REQ-013 wd_force_reset  output  1  SHALL drive the watchdog force-reset as a single-cycle pulse.
REQ-014 rf_mute  output  1  SHALL mute the AM carrier output when high.
REQ-015 fault_latched  output  1  SHALL report a latched watchdog fault.
REQ-016 missed_src  output  NUM_SRC  SHALL report sources absent in the last failed epoch.
REQ-017 state  output  2  SHALL report the FSM state: IDLE=0, ARMED=1, FAULT=2, RECOVER=3.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 IDLE: wd_enable=0, rf_mute=0; ARMED SHALL be entered on the cycle after src_en!=0.
REQ-020 ARMED: wd_enable=1; seen register SHALL accumulate seen |= src_alive & src_en each cycle; src_alive bits with src_en=0 SHALL be ignored.
REQ-021 Coverage SHALL be met when ((seen | (src_alive & src_en)) & src_en) == src_en; the next cycle SHALL emit wd_heartbeat=1 for exactly one cycle, clear seen, and reset the epoch counter to 0.
REQ-022 The epoch counter SHALL count 0..EPOCH_CYCLES-1 in ARMED; reaching EPOCH_CYCLES-1 without coverage SHALL load missed_src = src_en & ~seen, withhold the heartbeat, clear seen, and wrap to 0.
REQ-023 missed_src SHALL hold its value until the next failed epoch or reset; a successful epoch SHALL NOT clear it.
REQ-024 In ARMED, src_en==0 SHALL return the FSM to IDLE, clearing seen and the counter.
REQ-025 In ARMED, wd_triggered=1 SHALL move the FSM to FAULT next cycle; this SHALL take priority over coverage in the same cycle, and no heartbeat SHALL be emitted.
REQ-026 FAULT: rf_mute=1, fault_latched=1, wd_enable=1, and heartbeats SHALL be suppressed; clear_fault=1 SHALL move the FSM to RECOVER.
REQ-027 clear_fault outside FAULT SHALL be ignored.
REQ-028 RECOVER entry SHALL pulse wd_force_reset for one cycle; rf_mute SHALL stay 1 for MUTE_HOLD cycles.
REQ-029 RECOVER exit SHALL clear fault_latched, seen, and the counter, then go to ARMED, or to IDLE if src_en==0.
REQ-030 wd_triggered during RECOVER SHALL be ignored.
REQ-031 wd_heartbeat and wd_force_reset SHALL never be high in the same cycle.

Reset
REQ-032 rst=1 SHALL force state=IDLE, and set wd_enable, wd_heartbeat, wd_force_reset, rf_mute, and fault_latched to 0.
REQ-033 rst=1 SHALL also clear missed_src, seen, and the counter to 0.
REQ-034 rst SHALL take effect on the next rising edge from any state, including mid-RECOVER; reset SHALL dominate all inputs.

Verification
REQ-035 rst then src_en=4'b0011; alive[0] at cycle 5, alive[1] at cycle 9 -> one heartbeat pulse at cycle 10; seen cleared.
REQ-036 src_en=4'b0001, no alive for 1024 cycles -> no heartbeat, missed_src=4'b0001 after epoch end, counter wraps to 0.
REQ-037 ARMED, wd_triggered and covering alive in the same cycle -> state=FAULT, rf_mute=1, fault_latched=1, no heartbeat.
REQ-038 FAULT, then clear_fault -> one-cycle wd_force_reset, rf_mute held 16 cycles, then state=ARMED, fault_latched=0.
REQ-039 rst asserted at the 5th RECOVER cycle -> next cycle state=IDLE, all outputs 0.
REQ-040 src_en=4'b0010, alive pulses on bit 0 only -> bit 0 ignored, no heartbeat, missed_src=4'b0010.
